// File: rtl/median5_stream_if.sv
// rtl/median5_stream_if.sv - sample-in / sorted-window-out handshake bundle for median5_stream
//
// Purpose : groups the input sample handshake and the sorted result handshake.
// Signals : in_valid/in_ready/in_data - serial sample stream into the sorter
//           out_valid/out_ready       - result handshake toward downstream logic
//           x1..x5                    - sorted window, ascending (x1 smallest)
//           y                         - median, always equal to x3
// Modports: master - sample source / result consumer side
//           slave  - median5_stream side
interface median5_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic [WIDTH-1:0] x3;
  logic [WIDTH-1:0] x4;
  logic [WIDTH-1:0] x5;
  logic [WIDTH-1:0] y;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, x1, x2, x3, x4, x5, y
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, x1, x2, x3, x4, x5, y
  );
endinterface

// File: rtl/median5_stream.sv
// rtl/median5_stream.sv - streaming 5-sample median via one odd-even transposition pass per clock
//
// Purpose : collects 5 samples, sorts them over 5 clocks, presents x1..x5 and median y.
// Ports   : clk   - rising-edge clock
//           rst   - asynchronous active-high reset
//           clear - synchronous window flush / operation abort (beats in_valid and out_ready)
//           bus   - median5_stream_if.slave (in_valid/in_ready/in_data,
//                   out_valid/out_ready, x1..x5, y)
// Option  : MEDIAN5_SLIDING_WINDOW_EN - when defined the window slides (one result per
//           new sample after the first 5); undefined gives a tumbling window.
module median5_stream #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  median5_stream_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef MEDIAN5_SLIDING_WINDOW_EN
  // Window keeps its 5 samples; the next accept completes a fresh window.
  localparam logic [2:0] CNT_RELOAD = 3'd4;
`else
  localparam logic [2:0] CNT_RELOAD = 3'd0;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_cnt;
  logic [2:0]       r_pass;
  logic [WIDTH-1:0] r_win [5];   // arrival order, index 0 newest
  logic [WIDTH-1:0] r_srt [5];
  logic [WIDTH-1:0] r_x   [5];
  logic [WIDTH-1:0] w_win_shift [5];
  logic [WIDTH-1:0] w_pass_out  [5];

  // Window as it would look after accepting the current sample.
  always_comb begin
    w_win_shift[0] = bus.in_data;
    for (int i = 1; i < 5; i++) begin
      w_win_shift[i] = r_win[i-1];
    end
  end

  // One transposition pass; even passes touch (0,1),(2,3), odd passes (1,2),(3,4).
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_pass_out[i] = r_srt[i];
    end
    if (!r_pass[0]) begin
      if (r_srt[0] > r_srt[1]) begin
        w_pass_out[0] = r_srt[1];
        w_pass_out[1] = r_srt[0];
      end
      if (r_srt[2] > r_srt[3]) begin
        w_pass_out[2] = r_srt[3];
        w_pass_out[3] = r_srt[2];
      end
    end else begin
      if (r_srt[1] > r_srt[2]) begin
        w_pass_out[1] = r_srt[2];
        w_pass_out[2] = r_srt[1];
      end
      if (r_srt[3] > r_srt[4]) begin
        w_pass_out[3] = r_srt[4];
        w_pass_out[4] = r_srt[3];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD: if (!clear && bus.in_valid && r_cnt == 3'd4) w_next = SORT;
      SORT: begin
        if (clear)                w_next = LOAD;
        else if (r_pass == 3'd4)  w_next = DONE;
      end
      DONE: if (clear || bus.out_ready) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  // Output logic: handshake flags follow the state directly.
  always_comb begin
    bus.in_ready  = (r_state == LOAD);
    bus.out_valid = (r_state == DONE);
  end

  // Datapath: window, count, sort registers and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 3'd0;
      r_pass <= 3'd0;
      for (int i = 0; i < 5; i++) begin
        r_win[i] <= '0;
        r_srt[i] <= '0;
        r_x[i]   <= '0;
      end
    end else begin
      case (r_state)
        LOAD: begin
          if (clear) begin
            r_cnt <= 3'd0;
          end else if (bus.in_valid) begin
            for (int i = 0; i < 5; i++) begin
              r_win[i] <= w_win_shift[i];
            end
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd4) begin
              for (int i = 0; i < 5; i++) begin
                r_srt[i] <= w_win_shift[i];
              end
              r_pass <= 3'd0;
            end
          end
        end
        SORT: begin
          if (clear) begin
            r_cnt <= 3'd0;
          end else begin
            for (int i = 0; i < 5; i++) begin
              r_srt[i] <= w_pass_out[i];
            end
            r_pass <= r_pass + 3'd1;
            if (r_pass == 3'd4) begin
              for (int i = 0; i < 5; i++) begin
                r_x[i] <= w_pass_out[i];
              end
            end
          end
        end
        DONE: begin
          if (clear) begin
            r_cnt <= 3'd0;
          end else if (bus.out_ready) begin
            r_cnt <= CNT_RELOAD;
          end
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  assign bus.x1 = r_x[0];
  assign bus.x2 = r_x[1];
  assign bus.x3 = r_x[2];
  assign bus.x4 = r_x[3];
  assign bus.x5 = r_x[4];
  assign bus.y  = r_x[2];

endmodule

// File: tb/tb_median5_stream.sv
// tb/tb_median5_stream.sv - self-checking bench for median5_stream
module tb_median5_stream;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  median5_stream_if #(.WIDTH(W)) ifc ();

  median5_stream #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: list of accepted samples, a countdown for the sort, a done flag.
  int m_q[$];
  int m_s[$];
  int m_left;
  bit m_done;
  int m_pend[5];
  int m_x[5];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_left = 0;
      m_done = 0;
      for (int i = 0; i < 5; i++) m_x[i] = 0;
    end else if (clear) begin
      m_q.delete();
      m_left = 0;
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_x = m_pend;
        m_done = 1;
      end
    end else if (m_done) begin
      if (ifc.out_ready) begin
        m_done = 0;
`ifdef MEDIAN5_SLIDING_WINDOW_EN
        void'(m_q.pop_front());
`else
        m_q.delete();
`endif
      end
    end else if (ifc.in_valid) begin
      m_q.push_back(int'(ifc.in_data));
      if (m_q.size() > 5) void'(m_q.pop_front());
      if (m_q.size() == 5) begin
        m_s = m_q;
        m_s.sort();
        for (int i = 0; i < 5; i++) m_pend[i] = m_s[i];
        m_left = 5;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",  int'(ifc.in_ready),  int'(!(m_left > 0 || m_done)));
      chk("out_valid", int'(ifc.out_valid), int'(m_done));
      chk("x1", int'(ifc.x1), m_x[0]);
      chk("x2", int'(ifc.x2), m_x[1]);
      chk("x3", int'(ifc.x3), m_x[2]);
      chk("x4", int'(ifc.x4), m_x[3]);
      chk("x5", int'(ifc.x5), m_x[4]);
      chk("y",  int'(ifc.y),  m_x[2]);
    end
  end

  task automatic send(input int v);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_data  = v[7:0];
      ok = ifc.in_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    else @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    ifc.in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = ifc.out_valid;
    end
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  task automatic chk_x(input int a, input int b, input int c, input int d, input int e);
    chk("lit_x1", int'(ifc.x1), a);
    chk("lit_x2", int'(ifc.x2), b);
    chk("lit_x3", int'(ifc.x3), c);
    chk("lit_x4", int'(ifc.x4), d);
    chk("lit_x5", int'(ifc.x5), e);
    chk("lit_y",  int'(ifc.y),  c);
  endtask

  task automatic send5(input int a, input int b, input int c, input int d, input int e);
    send(a); send(b); send(c); send(d); send(e);
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    ifc.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", int'(ifc.in_ready), 1);
    chk("rst_out_valid", int'(ifc.out_valid), 0);
    chk_x(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic window, latency and single-cycle out_valid.
    send5(8, 12, 10, 5, 14);
    idle();
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (ifc.out_valid) lat = i;
    end
    chk("latency", lat, 5);
    chk_x(5, 8, 10, 12, 14);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", int'(ifc.out_valid), 0);

    // Backpressure: result held, pending sample 99 waits.
    do_clear();
    ifc.out_ready = 1'b0;
    send5(8, 12, 10, 5, 14);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data = 8'd99;
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      chk("hold_in_ready", int'(ifc.in_ready), 0);
      chk_x(5, 8, 10, 12, 14);
    end
    ifc.out_ready = 1'b1;
    send(99);
    idle();

    // Duplicates and extremes.
    do_clear();
    send5(7, 7, 3, 7, 3);
    idle();
    wait_valid();
    chk_x(3, 3, 7, 7, 7);
    do_clear();
    send5(255, 0, 255, 0, 128);
    idle();
    wait_valid();
    chk_x(0, 0, 128, 255, 255);

    // clear mid-window discards samples and the same-cycle offer.
    do_clear();
    send(1); send(2); send(3);
    @(negedge clk);
    clear = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data = 8'd77;
    @(negedge clk);
    clear = 1'b0;
    ifc.in_valid = 1'b0;
    send5(1, 2, 3, 4, 5);
    idle();
    wait_valid();
    chk_x(1, 2, 3, 4, 5);

    // Asynchronous reset during SORT.
    do_clear();
    send5(9, 8, 7, 6, 5);
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(ifc.out_valid), 0);
    chk("arst_in_ready", int'(ifc.in_ready), 1);
    chk_x(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    send5(40, 30, 50, 10, 20);
    idle();
    wait_valid();
    chk_x(10, 20, 30, 40, 50);

    // Window mode behaviour after the first result.
    do_clear();
    send5(8, 12, 10, 5, 14);
    idle();
    wait_valid();
    chk_x(5, 8, 10, 12, 14);
    send(1);
    idle();
`ifdef MEDIAN5_SLIDING_WINDOW_EN
    wait_valid();
    chk_x(1, 5, 10, 12, 14);
    send(20);
    idle();
    wait_valid();
    chk_x(1, 5, 10, 14, 20);
`else
    send(20);
    idle();
    repeat (10) begin
      @(negedge clk);
      chk("tumble_no_result", int'(ifc.out_valid), 0);
    end
`endif

    // Randomized traffic against the model.
    do_clear();
    repeat (600) begin
      @(negedge clk);
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.in_data   = 8'($urandom);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      clear         = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    clear = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
